// File: rtl/cpu_mem_pkg.sv
// Shared types and limits for the memory copy/fill master.
package cpu_mem_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_ISSUE,
        RD_WAIT,
        WR,
        FINISH
    } state_e;

    localparam int unsigned READ_LATENCY_MIN = 1;
    localparam int unsigned READ_LATENCY_MAX = 4;
    localparam int unsigned LAT_CNT_W        = 2;

    // Out-of-range latencies are pulled onto the nearest supported bound.
    function automatic int unsigned clamp_latency(input int unsigned lat);
        if (lat < READ_LATENCY_MIN) return READ_LATENCY_MIN;
        if (lat > READ_LATENCY_MAX) return READ_LATENCY_MAX;
        return lat;
    endfunction

endpackage

// File: rtl/cpu_mem_copy_master_if.sv
// Word-addressed synchronous memory port driven by the copy/fill master.
interface cpu_mem_copy_master_if #(
    parameter int unsigned ADDR_W = 16
);
    logic [ADDR_W-1:0] mem_address;
    logic              mem_chipselect;
    logic              mem_write;
    logic [3:0]        mem_byteenable;
    logic [31:0]       mem_writedata;
    logic              mem_clken;
    logic [31:0]       mem_readdata;

    modport master (
        output mem_address, mem_chipselect, mem_write, mem_byteenable,
               mem_writedata, mem_clken,
        input  mem_readdata
    );

    modport slave (
        input  mem_address, mem_chipselect, mem_write, mem_byteenable,
               mem_writedata, mem_clken,
        output mem_readdata
    );
endinterface

// File: rtl/cpu_mem_latency_counter.sv
// Times the RD_WAIT interval: last is high in the cycle read data is valid.
module cpu_mem_latency_counter
    import cpu_mem_pkg::*;
#(
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic en,
    output logic last
);
    localparam int unsigned LAT = clamp_latency(READ_LATENCY);

    logic [LAT_CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = LAT_CNT_W'(LAT - 1);
        end else if (en && cnt_q != '0) begin
            cnt_d = cnt_q - LAT_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign last = (cnt_q == '0);
endmodule

// File: rtl/cpu_mem_copy_master.sv
// Memory copy / pattern fill master: one word per read+write pair (copy) or
// one word per cycle (fill), abortable between words.
module cpu_mem_copy_master
    import cpu_mem_pkg::*;
#(
    parameter int unsigned ADDR_W       = 16,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_start,
    input  logic                  cmd_fill,
    input  logic [ADDR_W-1:0]     cmd_src,
    input  logic [ADDR_W-1:0]     cmd_dst,
    input  logic [ADDR_W:0]       cmd_len,
    input  logic [31:0]           cmd_pattern,
    input  logic                  cmd_abort,
    output logic                  busy,
    output logic                  done,
    output logic                  aborted,
    output logic [ADDR_W:0]       words_done,
    cpu_mem_copy_master_if.master mem
);
    localparam int unsigned CNT_W = ADDR_W + 1;

    state_e            state_q, state_d;
    logic              fill_q, fill_d;
    logic [CNT_W-1:0]  len_q, len_d;
    logic [31:0]       pattern_q, pattern_d;
    logic [ADDR_W-1:0] src_q, src_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [CNT_W-1:0]  words_done_q, words_done_d;
    logic              aborted_q, aborted_d;
    logic              abort_pend_q, abort_pend_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              cs_q, cs_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;

    logic              busy_now;
    logic              abort_now;
    logic [CNT_W-1:0]  wd_inc;
    logic [ADDR_W-1:0] src_cur, dst_cur;
    logic              fill_cur;
    logic [31:0]       pattern_cur;
    logic              lat_last;

    cpu_mem_latency_counter #(
        .READ_LATENCY(READ_LATENCY)
    ) u_lat (
        .clk   (clk),
        .reset (reset),
        .load  (state_q == RD_ISSUE),
        .en    (state_q == RD_WAIT),
        .last  (lat_last)
    );

    always_comb begin
        state_d      = state_q;
        fill_d       = fill_q;
        len_d        = len_q;
        pattern_d    = pattern_q;
        src_d        = src_q;
        dst_d        = dst_q;
        words_done_d = words_done_q;
        aborted_d    = aborted_q;
        abort_pend_d = abort_pend_q;
        cs_d         = 1'b0;
        wr_d         = 1'b0;
        addr_d       = addr_q;
        wdata_d      = wdata_q;

        busy_now  = (state_q == RD_ISSUE) || (state_q == RD_WAIT) || (state_q == WR);
        abort_now = abort_pend_q | (busy_now & cmd_abort);
        wd_inc    = words_done_q + CNT_W'(1);
        if (busy_now && cmd_abort) abort_pend_d = 1'b1;

        case (state_q)
            IDLE: begin
                if (cmd_start) begin
                    fill_d       = cmd_fill;
                    len_d        = cmd_len;
                    pattern_d    = cmd_pattern;
                    src_d        = cmd_src;
                    dst_d        = cmd_dst;
                    words_done_d = '0;
                    aborted_d    = 1'b0;
                    abort_pend_d = 1'b0;
                    if (cmd_len == '0) state_d = FINISH;
                    else if (cmd_fill) state_d = WR;
                    else               state_d = RD_ISSUE;
                end
            end
            RD_ISSUE: state_d = RD_WAIT;
            RD_WAIT:  if (lat_last) state_d = WR;
            WR: begin
                words_done_d = wd_inc;
                if (wd_inc == len_q || abort_now) begin
                    state_d   = FINISH;
                    aborted_d = abort_now;
                end else begin
                    state_d = fill_q ? WR : RD_ISSUE;
                end
            end
            FINISH: begin
                state_d      = IDLE;
                abort_pend_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase

        // Bus outputs are registered from the next state so they line up
        // with the state they belong to; in IDLE the command is not latched yet.
        src_cur     = (state_q == IDLE) ? cmd_src     : src_q;
        dst_cur     = (state_q == IDLE) ? cmd_dst     : dst_q;
        fill_cur    = (state_q == IDLE) ? cmd_fill    : fill_q;
        pattern_cur = (state_q == IDLE) ? cmd_pattern : pattern_q;

        if (state_d == RD_ISSUE) begin
            cs_d   = 1'b1;
            addr_d = src_cur;
            src_d  = src_cur + ADDR_W'(1);
        end
        if (state_d == WR) begin
            cs_d    = 1'b1;
            wr_d    = 1'b1;
            addr_d  = dst_cur;
            dst_d   = dst_cur + ADDR_W'(1);
            wdata_d = fill_cur ? pattern_cur : mem.mem_readdata;
        end

        busy_d = (state_d == RD_ISSUE) || (state_d == RD_WAIT) || (state_d == WR);
        done_d = (state_d == FINISH);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            fill_q       <= 1'b0;
            len_q        <= '0;
            pattern_q    <= '0;
            src_q        <= '0;
            dst_q        <= '0;
            words_done_q <= '0;
            aborted_q    <= 1'b0;
            abort_pend_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            cs_q         <= 1'b0;
            wr_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            fill_q       <= fill_d;
            len_q        <= len_d;
            pattern_q    <= pattern_d;
            src_q        <= src_d;
            dst_q        <= dst_d;
            words_done_q <= words_done_d;
            aborted_q    <= aborted_d;
            abort_pend_q <= abort_pend_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            cs_q         <= cs_d;
            wr_q         <= wr_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
        end
    end

    assign busy               = busy_q;
    assign done               = done_q;
    assign aborted            = aborted_q;
    assign words_done         = words_done_q;
    assign mem.mem_address    = addr_q;
    assign mem.mem_chipselect = cs_q;
    assign mem.mem_write      = wr_q;
    assign mem.mem_byteenable = '1;
    assign mem.mem_writedata  = wdata_q;
    assign mem.mem_clken      = 1'b1;
endmodule

// File: doc/cpu_mem_copy_master.md
CPU_MEM_COPY_MASTER -- requirements
Module: cpu_mem_copy_master

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, word-address width of the memory port.
REQ-002 SHALL have parameter READ_LATENCY, default 1, cycles from read-address cycle to valid mem_readdata (1..4).
REQ-003 Port: clk  in  1  sole clock, all logic rising-edge.
REQ-004 Port: reset  in  1  asynchronous, active-high reset.
REQ-005 Port: cmd_start  in  1  one-cycle command strobe.
REQ-006 Port: cmd_fill  in  1  1 = fill with cmd_pattern, 0 = copy.
REQ-007 Port: cmd_src  in  ADDR_W  copy source word address.
REQ-008 Port: cmd_dst  in  ADDR_W  destination word address.
REQ-009 Port: cmd_len  in  ADDR_W+1  word count (0..2^ADDR_W).
REQ-010 Port: cmd_pattern  in  32  fill data word.
REQ-011 Port: cmd_abort  in  1  stop after current access.
REQ-012 Port: busy  out  1  operation in progress.
REQ-013 Port: done  out  1  one-cycle completion pulse.
REQ-014 Port: aborted  out  1  qualifies done; high with done when ended by abort.
REQ-015 Port: words_done  out  ADDR_W+1  words written so far in current/last operation.
REQ-016 Port: mem_address  out  ADDR_W  memory word address.
REQ-017 Port: mem_chipselect  out  1  access strobe; read when mem_write=0.
REQ-018 Port: mem_write  out  1  write qualifier.
REQ-019 Port: mem_byteenable  out  4  always 4'hF during writes.
REQ-020 Port: mem_writedata  out  32  write data.
REQ-021 Port: mem_clken  out  1  constant 1.
REQ-022 Port: mem_readdata  in  32  memory read data.

Function
REQ-023 SHALL implement states IDLE, RD_ISSUE, RD_WAIT, WR, FINISH.
REQ-024 IDLE: cmd_start=1 latches all cmd_* and enters RD_ISSUE (copy) or WR (fill); cmd_len=0 enters FINISH directly with no memory access.
REQ-025 RD_ISSUE: one cycle, mem_chipselect=1, mem_write=0, mem_address=src pointer; then RD_WAIT.
REQ-026 RD_WAIT: counts READ_LATENCY-1 cycles (0 cycles when READ_LATENCY=1) with mem_chipselect=0, then captures mem_readdata into a data register in the cycle it is valid and enters WR.
REQ-027 WR: one cycle, mem_chipselect=1, mem_write=1, mem_address=dst pointer, mem_writedata=data register (copy) or pattern (fill); words_done increments.
REQ-028 After WR: if words_done equals cmd_len or abort pending, enter FINISH; else RD_ISSUE (copy) or WR again (fill, one word per cycle).
REQ-029 FINISH: done=1 for exactly one cycle, busy=0 in that cycle, return to IDLE.
REQ-030 busy SHALL be 1 in RD_ISSUE, RD_WAIT, WR; 0 in IDLE and FINISH.
REQ-031 Source and destination pointers SHALL increment by one after each use and wrap modulo 2^ADDR_W.
REQ-032 cmd_start while busy or in FINISH SHALL be ignored; no queuing.
REQ-033 cmd_abort SHALL set a sticky pending flag while busy; an in-flight read completes its WR unless abort arrives before RD_ISSUE (then FINISH without further access); no partial word writes.
REQ-034 cmd_abort in IDLE SHALL be ignored; aborted SHALL clear on next accepted command.
REQ-035 Overlapping copy regions SHALL be processed strictly ascending, no hazard correction.
REQ-036 Outside RD_ISSUE/WR mem_chipselect and mem_write SHALL be 0; mem_address/mem_writedata may hold.

Reset
REQ-037 reset SHALL asynchronously force IDLE, busy=0, done=0, aborted=0, words_done=0, mem_chipselect=0, mem_write=0, mem_address=0, mem_writedata=0, mem_byteenable=4'hF.
REQ-038 Reset mid-operation SHALL abandon the transfer without a done pulse.

Structure
REQ-039 State encoding enum and READ_LATENCY bounds SHALL reside in shared package cpu_mem_pkg.
REQ-040 Single module; optional sub-module cpu_mem_latency_counter for RD_WAIT timing.

Verification
REQ-041 Copy src=0x0010, dst=0x0100, len=4 with memory model latency 1 -> 4 reads then writes alternating, dst holds src data, done after 4th write, words_done=4.
REQ-042 Fill dst=0xFFFE, len=4, pattern 0xDEADBEEF -> writes to 0xFFFE,0xFFFF,0x0000,0x0001 on 4 consecutive cycles.
REQ-043 len=0 -> no chipselect, done one cycle after start, words_done=0.
REQ-044 READ_LATENCY=3 copy len=2 -> data captured 3 cycles after each read issue, correct destination words.
REQ-045 Abort during 3rd word of len=10 copy -> 3rd write completes, done+aborted, words_done=3.
REQ-046 Reset asserted mid-copy, cmd_start during busy -> outputs at reset values immediately, no done; ignored start causes no extra access.
